// File: rtl/btn_event.sv
// Debounced button level to single-cycle press/release/long/repeat events.
// BTN_EVENT_REPEAT_EN enables auto-repeat pulses in the LONG state.
module btn_event #(
   parameter int unsigned LONG_CYCLES   = 50000000,
   parameter int unsigned REPEAT_CYCLES = 10000000,
   parameter int unsigned CNT_W         = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic       repeat_pulse,
   output logic       held,
   output logic [7:0] press_cnt
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PRESSED,
      S_LONG
   } state_t;

   localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYCLES - 1);

   if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
      $error("btn_event: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
   end

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             btn_q;
   logic             press_q;
   logic             release_q;
   logic             long_q;
   logic             held_q;
   logic [7:0]       press_cnt_q;
   logic             rise_d;
   logic             fall_d;

   assign rise_d = btn_level & ~btn_q;
   assign fall_d = ~btn_level & btn_q;

`ifdef BTN_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);
   logic repeat_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         btn_q       <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         held_q      <= 1'b0;
         press_cnt_q <= '0;
`ifdef BTN_EVENT_REPEAT_EN
         repeat_q    <= 1'b0;
`endif
      end else begin
         btn_q     <= btn_level;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         long_q    <= 1'b0;
`ifdef BTN_EVENT_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (rise_d) begin
                  press_q     <= 1'b1;
                  press_cnt_q <= press_cnt_q + 8'd1;
                  cnt_q       <= '0;
                  state_q     <= S_PRESSED;
                  held_q      <= 1'b1;
               end
            end
            S_PRESSED: begin
               // release beats a coincident terminal count
               if (fall_d) begin
                  release_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_IDLE;
                  held_q    <= 1'b0;
               end else if (btn_level) begin
                  if (cnt_q == LONG_TERM) begin
                     long_q  <= 1'b1;
                     cnt_q   <= '0;
                     state_q <= S_LONG;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            S_LONG: begin
               if (fall_d) begin
                  release_q <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= S_IDLE;
                  held_q    <= 1'b0;
               end else if (btn_level) begin
`ifdef BTN_EVENT_REPEAT_EN
                  if (cnt_q == REPEAT_TERM) begin
                     repeat_q <= 1'b1;
                     cnt_q    <= '0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
`else
                  cnt_q <= '0;
`endif
               end
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= '0;
               held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign long_pulse    = long_q;
   assign held          = held_q;
   assign press_cnt     = press_cnt_q;
`ifdef BTN_EVENT_REPEAT_EN
   assign repeat_pulse  = repeat_q;
`else
   assign repeat_pulse  = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event.sv
// Randomized and directed bench for btn_event against a hold-age model.
// Build with or without BTN_EVENT_REPEAT_EN to match the DUT.
module tb_btn_event;

   localparam int LONG_C = 10;
   localparam int REP_C  = 4;

   logic       clk;
   logic       rst_n;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] press_cnt;

   btn_event #(
      .LONG_CYCLES  (LONG_C),
      .REPEAT_CYCLES(REP_C),
      .CNT_W        (8)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn_level    (btn_level),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse),
      .long_pulse   (long_pulse),
      .repeat_pulse (repeat_pulse),
      .held         (held),
      .press_cnt    (press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Model: a hold is tracked by its age in cycles since the press event.
   bit m_hold;
   bit m_prev;
   int m_age;
   int m_cnt;
   bit e_press, e_rel, e_long, e_rep;

   // Observed event bookkeeping for directed checks.
   int cyc_no;
   int n_long, n_rep, n_rel;
   int t_press, t_long;

   task automatic model_reset();
      m_hold = 0;
      m_prev = 0;
      m_age  = 0;
      m_cnt  = 0;
   endtask

   task automatic model_step(input bit lvl);
      e_press = 0;
      e_rel   = 0;
      e_long  = 0;
      e_rep   = 0;
      if (!m_hold) begin
         if (lvl && !m_prev) begin
            e_press = 1;
            m_hold  = 1;
            m_age   = 0;
            m_cnt   = (m_cnt + 1) % 256;
         end
      end else if (!lvl && m_prev) begin
         e_rel  = 1;
         m_hold = 0;
      end else begin
         m_age++;
         if (m_age == LONG_C) e_long = 1;
`ifdef BTN_EVENT_REPEAT_EN
         else if (m_age > LONG_C && (m_age - LONG_C) % REP_C == 0)
            e_rep = 1;
`endif
      end
      m_prev = lvl;
   endtask

   function automatic logic [12:0] outs();
      return {press_pulse, release_pulse, long_pulse, repeat_pulse,
              held, press_cnt};
   endfunction

   // One clock with btn_level = lvl sampled at the edge.
   task automatic cyc(input logic lvl);
      btn_level = lvl;
      @(posedge clk);
      model_step(lvl);
      #1;
      cyc_no++;
      chk("outs", 32'(outs()),
          32'({e_press, e_rel, e_long, e_rep, m_hold, 8'(m_cnt)}));
      if (press_pulse) t_press = cyc_no;
      if (long_pulse) begin
         t_long = cyc_no;
         n_long++;
      end
      if (repeat_pulse) n_rep++;
      if (release_pulse) n_rel++;
   endtask

   task automatic clr_obs();
      n_long = 0;
      n_rep  = 0;
      n_rel  = 0;
   endtask

   // Called just after an edge; asserts reset between edges.
   task automatic apply_reset(input logic lvl, input int n);
      btn_level = lvl;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 32'(outs()), 32'd0);
      model_reset();
      repeat (n) begin
         @(posedge clk);
         #1;
         chk("in_rst", 32'(outs()), 32'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      int hold_len;
      int exp_rep;
      rst_n     = 1'b0;
      btn_level = 1'b0;
      cyc_no    = 0;
      t_press   = 0;
      t_long    = 0;
      model_reset();
      clr_obs();
      @(posedge clk);
      #1;
      apply_reset(1'b0, 5);
      repeat (20) cyc(1'b0);

      // short press
      clr_obs();
      repeat (5) cyc(1'b1);
      repeat (3) cyc(1'b0);
      chk("short_cnt", 32'(press_cnt), 32'd1);
      chk("short_long", 32'(n_long), 32'd0);
      chk("short_rel", 32'(n_rel), 32'd1);

      // 30-cycle hold
      clr_obs();
      repeat (30) cyc(1'b1);
      repeat (3) cyc(1'b0);
      chk("long_once", 32'(n_long), 32'd1);
      chk("long_lat", 32'(t_long - t_press), 32'(LONG_C));
`ifdef BTN_EVENT_REPEAT_EN
      exp_rep = 4;
`else
      exp_rep = 0;
`endif
      chk("rep_count", 32'(n_rep), 32'(exp_rep));
      chk("long_rel", 32'(n_rel), 32'd1);

      // fall sampled on the terminal-count edge
      clr_obs();
      repeat (LONG_C) cyc(1'b1);
      cyc(1'b0);
      chk("term_rel", 32'(release_pulse), 32'd1);
      chk("term_held", 32'(held), 32'd0);
      repeat (3) cyc(1'b0);
      chk("term_nolong", 32'(n_long), 32'd0);

      // reset while in LONG, button still down through reset release
      clr_obs();
      repeat (15) cyc(1'b1);
      chk("pre_rst_held", 32'(held), 32'd1);
      apply_reset(1'b1, 3);
      chk("rst_norel", 32'(n_rel), 32'd0);
      cyc(1'b1);
      chk("rst_press", 32'(press_pulse), 32'd1);
      repeat (3) cyc(1'b0);

      // 256 short presses wrap the counter
      @(posedge clk);
      #1;
      apply_reset(1'b0, 2);
      for (int i = 0; i < 256; i++) begin
         cyc(1'b1);
         cyc(1'b1);
         cyc(1'b0);
      end
      chk("wrap_cnt", 32'(press_cnt), 32'd0);

      // random holds, biased around the long boundary
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 2) == 0)
            hold_len = $urandom_range(LONG_C - 1, LONG_C + 1);
         else
            hold_len = $urandom_range(1, 3 * LONG_C);
         repeat (hold_len) cyc(1'b1);
         repeat ($urandom_range(1, 4)) cyc(1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
